// File: rtl/hazard_ctrl_pkg.sv
// Shared widths, FSM encodings and scoreboard entry type for the hazard controller.
package hazard_ctrl_pkg;
    localparam int ARCH_LEN  = 32;
    localparam int REG_IDX_W = 5;
    localparam int SB_SLOTS  = 3;   // 0=EXE, 1=MEM, 2=WB

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] ST_REDIRECT = 2'd2;

    typedef struct packed {
        logic                 valid;
        logic [REG_IDX_W-1:0] rd;
        logic                 is_load;
    } sb_entry_t;
endpackage

// File: rtl/hazard_ctrl_sb_match.sv
// Per-slot RAW match of the decode sources against the in-flight scoreboard.
module sb_match
    import hazard_ctrl_pkg::*;
(
    input  logic [REG_IDX_W-1:0]         i_rs1,
    input  logic [REG_IDX_W-1:0]         i_rs2,
    input  logic                         i_use_rs1,
    input  logic                         i_use_rs2,
    input  sb_entry_t [SB_SLOTS-1:0]     i_slots,
    output logic [SB_SLOTS-1:0]          o_match
);
    for (genvar g = 0; g < SB_SLOTS; g++) begin : g_slot
        // x0 is hardwired to zero, so a write to it never creates a dependency
        assign o_match[g] = i_slots[g].valid && (i_slots[g].rd != '0) &&
                            ((i_use_rs1 && (i_slots[g].rd == i_rs1)) ||
                             (i_use_rs2 && (i_slots[g].rd == i_rs2)));
    end
endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard / redirect / dcache-miss sequencing for the 5-stage core.
// Define HAZARD_BYPASS_EN when forwarding exists: only load-use in EXE stalls.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid_in,
    input  logic [REG_IDX_W-1:0] id_rs1_in,
    input  logic [REG_IDX_W-1:0] id_rs2_in,
    input  logic                 id_use_rs1_in,
    input  logic                 id_use_rs2_in,
    input  logic [REG_IDX_W-1:0] id_rd_in,
    input  logic                 id_wr_rd_in,
    input  logic                 id_is_load_in,
    input  logic                 kill_exe_in,
    input  logic [ARCH_LEN-1:0]  pc_br_tk_in,
    input  logic                 mem_miss_in,
    input  logic                 mem_fill_done_in,
    output logic                 stall_if_out,
    output logic                 stall_id_out,
    output logic                 stall_exe_out,
    output logic                 stall_mem_out,
    output logic                 flush_if_out,
    output logic                 flush_id_out,
    output logic                 bubble_exe_out,
    output logic                 redirect_valid_out,
    output logic [ARCH_LEN-1:0]  redirect_pc_out
);
    logic [1:0]                r_state;
    logic                      r_pend;
    logic [ARCH_LEN-1:0]       r_tgt;
    sb_entry_t [SB_SLOTS-1:0]  r_sb;

    logic [1:0]                w_state_nxt;
    logic [SB_SLOTS-1:0]       w_match;
    logic                      w_hazard;
    logic                      w_capture;

    sb_match u_sb_match (
        .i_rs1     (id_rs1_in),
        .i_rs2     (id_rs2_in),
        .i_use_rs1 (id_use_rs1_in),
        .i_use_rs2 (id_use_rs2_in),
        .i_slots   (r_sb),
        .o_match   (w_match)
    );

`ifdef HAZARD_BYPASS_EN
    assign w_hazard = id_valid_in && |(w_match & {{(SB_SLOTS-1){1'b0}}, r_sb[0].is_load});
`else
    assign w_hazard = id_valid_in && |w_match;
`endif

    // A kill that coincides with or follows a miss is remembered and replayed after the fill
    assign w_capture = kill_exe_in &&
                       (((r_state == ST_RUN) && mem_miss_in) || (r_state == ST_MEM_WAIT));

    always_comb begin
        w_state_nxt        = ST_RUN;
        stall_if_out       = 1'b0;
        stall_id_out       = 1'b0;
        stall_exe_out      = 1'b0;
        stall_mem_out      = 1'b0;
        flush_if_out       = 1'b0;
        flush_id_out       = 1'b0;
        bubble_exe_out     = 1'b0;
        redirect_valid_out = 1'b0;
        redirect_pc_out    = '0;
        case (r_state)
            ST_RUN: begin
                if (mem_miss_in) begin
                    {stall_if_out, stall_id_out, stall_exe_out, stall_mem_out} = 4'hF;
                    w_state_nxt = ST_MEM_WAIT;
                end else if (kill_exe_in) begin
                    flush_if_out       = 1'b1;
                    flush_id_out       = 1'b1;
                    redirect_valid_out = 1'b1;
                    redirect_pc_out    = pc_br_tk_in;
                end else if (w_hazard) begin
                    stall_if_out   = 1'b1;
                    stall_id_out   = 1'b1;
                    bubble_exe_out = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                if (mem_fill_done_in)
                    w_state_nxt = (r_pend || kill_exe_in) ? ST_REDIRECT : ST_RUN;
                else begin
                    {stall_if_out, stall_id_out, stall_exe_out, stall_mem_out} = 4'hF;
                    w_state_nxt = ST_MEM_WAIT;
                end
            end
            ST_REDIRECT: begin
                flush_if_out       = 1'b1;
                flush_id_out       = 1'b1;
                redirect_valid_out = 1'b1;
                redirect_pc_out    = r_tgt;
            end
            default: w_state_nxt = ST_RUN;
        endcase
        if (rst) begin
            stall_if_out       = 1'b0;
            stall_id_out       = 1'b0;
            stall_exe_out      = 1'b0;
            stall_mem_out      = 1'b0;
            flush_if_out       = 1'b0;
            flush_id_out       = 1'b0;
            bubble_exe_out     = 1'b0;
            redirect_valid_out = 1'b0;
            redirect_pc_out    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
            r_pend  <= 1'b0;
            r_tgt   <= '0;
            r_sb    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_capture) begin
                r_pend <= 1'b1;
                r_tgt  <= pc_br_tk_in;
            end else if (r_state == ST_REDIRECT) begin
                r_pend <= 1'b0;
            end
            // stall_mem_out only rises together with the other three stalls
            if (!stall_mem_out) begin
                r_sb[2]         <= r_sb[1];
                r_sb[1]         <= r_sb[0];
                r_sb[0].valid   <= id_valid_in && id_wr_rd_in && !stall_id_out && !flush_id_out;
                r_sb[0].rd      <= id_rd_in;
                r_sb[0].is_load <= id_is_load_in;
            end
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl; expectations follow HAZARD_BYPASS_EN.
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

`ifdef HAZARD_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    // {stall_if, stall_id, stall_exe, stall_mem, flush_if, flush_id, bubble, redirect}
    localparam logic [7:0] O_IDLE = 8'b0000_0000;
    localparam logic [7:0] O_HAZ  = 8'b1100_0010;
    localparam logic [7:0] O_ALL  = 8'b1111_0000;
    localparam logic [7:0] O_KILL = 8'b0000_1101;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 id_valid_in, id_use_rs1_in, id_use_rs2_in, id_wr_rd_in, id_is_load_in;
    logic [REG_IDX_W-1:0] id_rs1_in, id_rs2_in, id_rd_in;
    logic                 kill_exe_in, mem_miss_in, mem_fill_done_in;
    logic [ARCH_LEN-1:0]  pc_br_tk_in;
    logic                 stall_if_out, stall_id_out, stall_exe_out, stall_mem_out;
    logic                 flush_if_out, flush_id_out, bubble_exe_out, redirect_valid_out;
    logic [ARCH_LEN-1:0]  redirect_pc_out;
    logic [7:0]           outs;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign outs = {stall_if_out, stall_id_out, stall_exe_out, stall_mem_out,
                   flush_if_out, flush_id_out, bubble_exe_out, redirect_valid_out};

    hazard_ctrl dut (
        .clk(clk), .rst(rst),
        .id_valid_in(id_valid_in), .id_rs1_in(id_rs1_in), .id_rs2_in(id_rs2_in),
        .id_use_rs1_in(id_use_rs1_in), .id_use_rs2_in(id_use_rs2_in),
        .id_rd_in(id_rd_in), .id_wr_rd_in(id_wr_rd_in), .id_is_load_in(id_is_load_in),
        .kill_exe_in(kill_exe_in), .pc_br_tk_in(pc_br_tk_in),
        .mem_miss_in(mem_miss_in), .mem_fill_done_in(mem_fill_done_in),
        .stall_if_out(stall_if_out), .stall_id_out(stall_id_out),
        .stall_exe_out(stall_exe_out), .stall_mem_out(stall_mem_out),
        .flush_if_out(flush_if_out), .flush_id_out(flush_id_out),
        .bubble_exe_out(bubble_exe_out), .redirect_valid_out(redirect_valid_out),
        .redirect_pc_out(redirect_pc_out)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clr_in();
        id_valid_in = 0; id_use_rs1_in = 0; id_use_rs2_in = 0; id_wr_rd_in = 0;
        id_is_load_in = 0; id_rs1_in = 0; id_rs2_in = 0; id_rd_in = 0;
        kill_exe_in = 0; mem_miss_in = 0; mem_fill_done_in = 0; pc_br_tk_in = 0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic produce(input logic [4:0] rd, input logic ld);
        clr_in();
        id_valid_in = 1; id_rd_in = rd; id_wr_rd_in = 1; id_is_load_in = ld;
    endtask

    task automatic consume(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2);
        clr_in();
        id_valid_in = 1; id_rs1_in = rs1; id_use_rs1_in = u1; id_rs2_in = rs2; id_use_rs2_in = u2;
    endtask

    // Hold a consumer in decode and count the stall cycles it sees (bounded).
    task automatic count_stalls(input string tag, input logic [4:0] rs1, input logic u1,
                                input logic [4:0] rs2, input logic u2, input int exp_n);
        int  n = 0;
        bit  done = 0;
        consume(rs1, u1, rs2, u2);
        for (int c = 0; c < 6 && !done; c++) begin
            #2;
            if (stall_id_out) begin
                n++;
                chk({tag, "_stall"}, 32'(outs), 32'(O_HAZ));
            end else done = 1;
            tick();
        end
        chk({tag, "_cnt"}, n, exp_n);
        clr_in();
        repeat (3) tick();
    endtask

    task automatic run_pair(input string tag, input logic [4:0] rd, input logic ld,
                            input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                            input logic u2, input int exp_n);
        produce(rd, ld);
        #2 chk({tag, "_prod"}, 32'(outs), 32'(O_IDLE));
        tick();
        count_stalls(tag, rs1, u1, rs2, u2, exp_n);
    endtask

    initial begin
        clr_in();
        rst = 1;
        kill_exe_in = 1; mem_miss_in = 1; pc_br_tk_in = 32'h123;
        id_valid_in = 1; id_wr_rd_in = 1; id_rd_in = 5'd3;
        tick(); tick();
        #2 chk("rst_outs", 32'(outs), 32'(O_IDLE));
        chk("rst_pc", redirect_pc_out, 32'h0);
        clr_in();
        rst = 0;
        tick();
        #2 chk("idle", 32'(outs), 32'(O_IDLE));
        tick();

        // RAW patterns
        run_pair("alu_use",  5'd5, 1'b0, 5'd5, 1, 5'd5, 1, BYP ? 0 : 3);
        run_pair("load_use", 5'd5, 1'b1, 5'd5, 1, 5'd1, 1, BYP ? 1 : 3);
        run_pair("rs2_load", 5'd8, 1'b1, 5'd1, 1, 5'd8, 1, BYP ? 1 : 3);
        run_pair("rs2_alu",  5'd8, 1'b0, 5'd1, 1, 5'd8, 1, BYP ? 0 : 3);
        run_pair("x0_use",   5'd0, 1'b1, 5'd0, 1, 5'd0, 1, 0);
        run_pair("unused",   5'd7, 1'b1, 5'd7, 0, 5'd7, 0, 0);

        // kill beats a concurrent load-use hazard
        produce(5'd5, 1'b1);
        tick();
        consume(5'd5, 1, 5'd0, 0);
        kill_exe_in = 1; pc_br_tk_in = 32'h0000_0100;
        #2 chk("kill_outs", 32'(outs), 32'(O_KILL));
        chk("kill_pc", redirect_pc_out, 32'h100);
        tick();
        clr_in();
        repeat (3) tick();

        // miss: 5 cycles of full stall, scoreboard frozen meanwhile
        produce(5'd9, 1'b1);
        tick();
        clr_in();
        mem_miss_in = 1;
        #2 chk("miss_c0", 32'(outs), 32'(O_ALL));
        tick();
        mem_miss_in = 0;
        for (int i = 1; i <= 4; i++) begin
            #2 chk($sformatf("miss_c%0d", i), 32'(outs), 32'(O_ALL));
            tick();
        end
        mem_fill_done_in = 1;
        #2 chk("miss_fill", 32'(outs), 32'(O_IDLE));
        tick();
        clr_in();
        // the load has now advanced exactly one slot, to MEM
        count_stalls("miss_sb", 5'd9, 1, 5'd0, 0, BYP ? 0 : 2);

        // fill_done in RUN is ignored
        mem_fill_done_in = 1;
        #2 chk("fill_run", 32'(outs), 32'(O_IDLE));
        tick();
        clr_in();
        #2 chk("fill_run_nxt", 32'(outs), 32'(O_IDLE));
        tick();

        // kill in the miss cycle is deferred until after the fill
        mem_miss_in = 1; kill_exe_in = 1; pc_br_tk_in = 32'h200;
        #2 chk("kmiss_c0", 32'(outs), 32'(O_ALL));
        tick();
        clr_in(); pc_br_tk_in = 32'h333;
        #2 chk("kmiss_wait", 32'(outs), 32'(O_ALL));
        tick();
        mem_fill_done_in = 1;
        #2 chk("kmiss_fill", 32'(outs), 32'(O_IDLE));
        tick();
        clr_in(); pc_br_tk_in = 32'h333;
        #2 chk("kmiss_redir", 32'(outs), 32'(8'b0000_1101));
        chk("kmiss_pc", redirect_pc_out, 32'h200);
        tick();
        #2 chk("kmiss_run", 32'(outs), 32'(O_IDLE));
        tick();

        // kill seen during MEM_WAIT
        clr_in(); mem_miss_in = 1;
        tick();
        clr_in(); kill_exe_in = 1; pc_br_tk_in = 32'h300;
        #2 chk("kwait_outs", 32'(outs), 32'(O_ALL));
        tick();
        clr_in(); mem_fill_done_in = 1;
        tick();
        clr_in();
        #2 chk("kwait_redir", 32'(outs), 32'(O_KILL));
        chk("kwait_pc", redirect_pc_out, 32'h300);
        tick();

        // reset while a miss with a pending redirect is outstanding
        mem_miss_in = 1; kill_exe_in = 1; pc_br_tk_in = 32'h400;
        tick();
        clr_in();
        tick();
        rst = 1;
        #2 chk("rstw_during", 32'(outs), 32'(O_IDLE));
        tick();
        rst = 0;
        #2 chk("rstw_after", 32'(outs), 32'(O_IDLE));
        chk("rstw_pc", redirect_pc_out, 32'h0);
        mem_fill_done_in = 1;
        tick();
        clr_in();
        #2 chk("rstw_noredir", 32'(outs), 32'(O_IDLE));
        kill_exe_in = 1; pc_br_tk_in = 32'h500;
        #1 chk("rstw_run_kill", 32'(outs), 32'(O_KILL));
        chk("rstw_run_pc", redirect_pc_out, 32'h500);
        tick();
        clr_in();
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
